// File: rtl/alu_arbiter_if.sv
// Handshake and datapath bundle between the issue logic, alu_arbiter and the ALU pair.
// slave = arbiter view, master = surrounding logic (requesters plus ALU datapath).
interface alu_arbiter_if #(
  parameter int OPWIDTH = 4,
  parameter int DWIDTH  = 16
);
  logic               req0_valid;
  logic               req0_ready;
  logic [OPWIDTH-1:0] req0_opcode;
  logic [DWIDTH-1:0]  req0_a;
  logic [DWIDTH-1:0]  req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [OPWIDTH-1:0] req1_opcode;
  logic [DWIDTH-1:0]  req1_a;
  logic [DWIDTH-1:0]  req1_b;
  logic [OPWIDTH-1:0] alu_opcode;
  logic [DWIDTH-1:0]  alu_a;
  logic [DWIDTH-1:0]  alu_b;
  logic [DWIDTH-1:0]  alu_result;
  logic [2:0]         alu_flags;
  logic               rsp_valid;
  logic               rsp_id;
  logic [DWIDTH-1:0]  rsp_result;
  logic [2:0]         rsp_flags;
  logic               busy;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  alu_result, alu_flags,
    output req0_ready, req1_ready,
    output alu_opcode, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, busy
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output alu_result, alu_flags,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU controller/datapath pair.
// Define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority; default is round-robin.
`ifndef cCLR
`define cCLR    4'h0
`endif
`ifndef cADD_AB
`define cADD_AB 4'h1
`endif
`ifndef cSUB_AB
`define cSUB_AB 4'h2
`endif
`ifndef cMUL_AB
`define cMUL_AB 4'h3
`endif
`ifndef cCMP_AB
`define cCMP_AB 4'h4
`endif

module alu_arbiter #(
  parameter int OPWIDTH = 4,
  parameter int DWIDTH  = 16,
  parameter int ALU_LAT = 2,
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [OPWIDTH-1:0] OP_CLR  = OPWIDTH'(`cCLR);
  localparam logic [OPWIDTH-1:0] OP_MUL  = OPWIDTH'(`cMUL_AB);
  localparam logic [CNT_W-1:0]   CNT_ALU = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_MUL = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [OPWIDTH-1:0] alu_opcode_reg;
  logic [DWIDTH-1:0]  alu_a_reg;
  logic [DWIDTH-1:0]  alu_b_reg;
  logic               rsp_valid_reg;
  logic               rsp_id_reg;
  logic [DWIDTH-1:0]  rsp_result_reg;
  logic [2:0]         rsp_flags_reg;
  logic               busy_reg;

  logic               grant_id;
  logic               accept;
  logic [OPWIDTH-1:0] sel_opcode;
  logic [DWIDTH-1:0]  sel_a;
  logic [DWIDTH-1:0]  sel_b;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // req1 is only picked when req0 is absent.
  assign grant_id = !bus.req0_valid;
`else
  logic last_reg;
  assign grant_id = (bus.req0_valid && bus.req1_valid) ? !last_reg : bus.req1_valid;
`endif

  // Ready is a function of state and the two valids only.
  assign accept         = (state_reg == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = (state_reg == IDLE) && bus.req0_valid && !grant_id;
  assign bus.req1_ready = (state_reg == IDLE) && bus.req1_valid && grant_id;

  assign sel_opcode = grant_id ? bus.req1_opcode : bus.req0_opcode;
  assign sel_a      = grant_id ? bus.req1_a      : bus.req0_a;
  assign sel_b      = grant_id ? bus.req1_b      : bus.req0_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      alu_opcode_reg <= OP_CLR;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
      busy_reg       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_reg       <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          rsp_valid_reg <= 1'b0;
          if (accept) begin
            alu_opcode_reg <= sel_opcode;
            alu_a_reg      <= sel_a;
            alu_b_reg      <= sel_b;
            rsp_id_reg     <= grant_id;
            cnt_reg        <= (sel_opcode == OP_MUL) ? CNT_MUL : CNT_ALU;
            busy_reg       <= 1'b1;
            state_reg      <= EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_reg       <= grant_id;
`endif
          end
        end
        EXEC: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            rsp_result_reg <= bus.alu_result;
            rsp_flags_reg  <= bus.alu_flags;
            alu_opcode_reg <= OP_CLR;
            rsp_valid_reg  <= 1'b1;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg      <= IDLE;
          alu_opcode_reg <= OP_CLR;
          rsp_valid_reg  <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_opcode = alu_opcode_reg;
  assign bus.alu_a      = alu_a_reg;
  assign bus.alu_b      = alu_b_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_flags  = rsp_flags_reg;
  assign bus.busy       = busy_reg;
endmodule
